// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl
// Top-level Pac-Man game-flow sequencer. Walks the game through the attract,
// ready, play, death, level-clear and game-over phases, freezes sprites
// outside PLAY, drives the lives register's Restart input, and uses its
// Reset_game answer to choose between respawn and game over.
//
// Ports
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   frame_tick   one-Clk pulse per video frame
//   Start        start key (level)
//   Caught       ghost/Pac-Man collision (level)
//   Dots_done    all pellets eaten (level)
//   Reset_game   from lives register, valid one cycle after Restart
//   Restart      consume one life (high for the single LOSE cycle)
//   Freeze       high whenever state != PLAY
//   Respawn      registered pulse: sprites back to start positions
//   New_game     registered pulse: clear score, reload dot map
//   Level_up     registered pulse: reload dot map, advance speed table
//   Show_ready   high in READY
//   Show_over    high in OVER
//   level        current level, 0-based, saturates at 15
//   state        state encoding for debug/HUD
module game_seq_ctrl #(
  parameter int unsigned READY_FRAMES = 120,
  parameter int unsigned DEATH_FRAMES = 90,
  parameter int unsigned CLEAR_FRAMES = 120,
  parameter int unsigned OVER_FRAMES  = 180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       Start,
  input  logic       Caught,
  input  logic       Dots_done,
  input  logic       Reset_game,
  output logic       Restart,
  output logic       Freeze,
  output logic       Respawn,
  output logic       New_game,
  output logic       Level_up,
  output logic       Show_ready,
  output logic       Show_over,
  output logic [3:0] level,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_LOSE  = 3'd4,
    S_CHECK = 3'd5,
    S_CLEAR = 3'd6,
    S_OVER  = 3'd7
  } state_t;

  localparam logic [7:0] READY_LOAD = 8'(READY_FRAMES);
  localparam logic [7:0] DEATH_LOAD = 8'(DEATH_FRAMES);
  localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_FRAMES);
  localparam logic [7:0] OVER_LOAD  = 8'(OVER_FRAMES);

  state_t     cur, nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] level_nxt;
  logic       respawn_nxt, new_game_nxt, level_up_nxt;

  // Exit fires on the tick that takes the counter from 1 to 0, so a timed
  // state lasts exactly N ticks. Ticks in the entry cycle are not seen here
  // because the counter is only consulted once we are already in the state.
  logic last_tick;
  assign last_tick = frame_tick && (cnt == 8'd1);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    nxt          = cur;
    cnt_nxt      = cnt;
    level_nxt    = level;
    respawn_nxt  = 1'b0;
    new_game_nxt = 1'b0;
    level_up_nxt = 1'b0;

    if (frame_tick && cur inside {S_READY, S_DYING, S_CLEAR, S_OVER})
      cnt_nxt = cnt - 8'd1;

    unique case (cur)
      S_IDLE: if (Start) begin
        nxt          = S_READY;
        cnt_nxt      = READY_LOAD;
        level_nxt    = 4'd0;
        new_game_nxt = 1'b1;
        respawn_nxt  = 1'b1;
      end
      S_READY: if (last_tick) nxt = S_PLAY;
      S_PLAY: begin
        // Clearing the maze outranks a simultaneous collision.
        if (Dots_done) begin
          nxt     = S_CLEAR;
          cnt_nxt = CLEAR_LOAD;
        end else if (Caught) begin
          nxt     = S_DYING;
          cnt_nxt = DEATH_LOAD;
        end
      end
      S_DYING: if (last_tick) nxt = S_LOSE;
      S_LOSE:  nxt = S_CHECK;
      // Reset_game answers the Restart issued in LOSE one cycle earlier.
      S_CHECK: begin
        if (Reset_game) begin
          nxt     = S_OVER;
          cnt_nxt = OVER_LOAD;
        end else begin
          nxt         = S_READY;
          cnt_nxt     = READY_LOAD;
          respawn_nxt = 1'b1;
        end
      end
      S_CLEAR: if (last_tick) begin
        nxt          = S_READY;
        cnt_nxt      = READY_LOAD;
        level_up_nxt = 1'b1;
        respawn_nxt  = 1'b1;
        level_nxt    = (level == 4'd15) ? level : level + 4'd1;
      end
      S_OVER: if (last_tick) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (Reset) begin
      cur      <= S_IDLE;
      cnt      <= 8'd0;
      level    <= 4'd0;
      Respawn  <= 1'b0;
      New_game <= 1'b0;
      Level_up <= 1'b0;
    end else begin
      cur      <= nxt;
      cnt      <= cnt_nxt;
      level    <= level_nxt;
      Respawn  <= respawn_nxt;
      New_game <= new_game_nxt;
      Level_up <= level_up_nxt;
    end
  end

  assign state      = cur;
  assign Freeze     = (cur != S_PLAY);
  assign Restart    = (cur == S_LOSE);
  assign Show_ready = (cur == S_READY);
  assign Show_over  = (cur == S_OVER);

endmodule

// File: tb/tb_game_seq_ctrl.sv
// tb_game_seq_ctrl
// Bench for game_seq_ctrl with short phase lengths. Contains a small lives
// register (3 lives) fed by Restart, a directed vector table, a level
// saturation sequence, and a randomized run compared against a phase model.
module tb_game_seq_ctrl;

  localparam int RF = 3;
  localparam int DF = 2;
  localparam int CF = 2;
  localparam int OF = 2;

  logic       clk = 1'b0;
  logic       rst, tick, start, caught, dots;
  logic       reset_game;
  logic       restart, freeze, respawn, new_game, level_up, show_ready, show_over;
  logic [3:0] level;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_seq_ctrl #(
    .READY_FRAMES(RF), .DEATH_FRAMES(DF), .CLEAR_FRAMES(CF), .OVER_FRAMES(OF)
  ) dut (
    .Clk(clk), .Reset(rst), .frame_tick(tick), .Start(start), .Caught(caught),
    .Dots_done(dots), .Reset_game(reset_game), .Restart(restart),
    .Freeze(freeze), .Respawn(respawn), .New_game(new_game),
    .Level_up(level_up), .Show_ready(show_ready), .Show_over(show_over),
    .level(level), .state(state)
  );

  // Lives register: starts at 3, reloads on New_game, answers one cycle
  // after Restart with Reset_game=1 when the last life was just consumed.
  int lives;
  always @(posedge clk) begin
    if (rst) begin
      lives      <= 3;
      reset_game <= 1'b0;
    end else begin
      reset_game <= restart && (lives == 1);
      if (new_game)     lives <= 3;
      else if (restart) lives <= lives - 1;
    end
  end

  // Phase model: phase number, frames remaining, level and pending pulses.
  localparam int P_IDLE = 0, P_READY = 1, P_PLAY = 2, P_DYING = 3;
  localparam int P_LOSE = 4, P_CHECK = 5, P_CLEAR = 6, P_OVER = 7;
  int m_ph = P_IDLE, m_left = 0, m_lvl = 0;
  bit m_rp = 0, m_ng = 0, m_lu = 0;

  always @(posedge clk) begin
    m_rp = 0; m_ng = 0; m_lu = 0;
    if (rst) begin
      m_ph = P_IDLE; m_left = 0; m_lvl = 0;
    end else begin
      case (m_ph)
        P_IDLE:  if (start) begin m_ph = P_READY; m_left = RF; m_lvl = 0; m_ng = 1; m_rp = 1; end
        P_READY: if (tick) begin m_left--; if (m_left == 0) m_ph = P_PLAY; end
        P_PLAY:  if (dots) begin m_ph = P_CLEAR; m_left = CF; end
                 else if (caught) begin m_ph = P_DYING; m_left = DF; end
        P_DYING: if (tick) begin m_left--; if (m_left == 0) m_ph = P_LOSE; end
        P_LOSE:  m_ph = P_CHECK;
        P_CHECK: if (reset_game) begin m_ph = P_OVER; m_left = OF; end
                 else begin m_ph = P_READY; m_left = RF; m_rp = 1; end
        P_CLEAR: if (tick) begin
                   m_left--;
                   if (m_left == 0) begin
                     m_ph = P_READY; m_left = RF; m_lu = 1; m_rp = 1;
                     if (m_lvl < 15) m_lvl++;
                   end
                 end
        P_OVER:  if (tick) begin m_left--; if (m_left == 0) m_ph = P_IDLE; end
        default: m_ph = P_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs for one edge, return at the following falling edge.
  task automatic step(input logic r, input logic t, input logic s, input logic c, input logic d);
    rst = r; tick = t; start = s; caught = c; dots = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Flags in order {Freeze, Restart, Respawn, New_game, Level_up, Show_ready, Show_over}
  function automatic logic [6:0] dut_flags();
    return {freeze, restart, respawn, new_game, level_up, show_ready, show_over};
  endfunction

  typedef struct packed {
    logic       r, t, s, c, d;
    logic [2:0] st;
    logic       rs, rp, ng, lu;
    logic [3:0] lv;
  } vec_t;

  function automatic vec_t mk(logic r, logic t, logic s, logic c, logic d,
                              logic [2:0] st, logic rs, logic rp, logic ng,
                              logic lu, logic [3:0] lv);
    vec_t v;
    v.r = r; v.t = t; v.s = s; v.c = c; v.d = d;
    v.st = st; v.rs = rs; v.rp = rp; v.ng = ng; v.lu = lu; v.lv = lv;
    return v;
  endfunction

  vec_t vq[$];

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; caught = 1'b0; dots = 1'b0;

    //            r t s c d  st rs rp ng lu lv
    vq.push_back(mk(1,0,0,0,0, 0, 0, 0, 0, 0, 0));  // reset
    vq.push_back(mk(0,0,0,0,0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,0,1,0,0, 1, 0, 1, 1, 0, 0));  // start -> READY
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0,0,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 2, 0, 0, 0, 0, 0));  // 3rd tick -> PLAY
    vq.push_back(mk(0,0,0,1,0, 3, 0, 0, 0, 0, 0));  // Caught held 10 cycles
    vq.push_back(mk(0,1,0,1,0, 3, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0,1,0, 3, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,1,0, 4, 1, 0, 0, 0, 0));  // LOSE, Restart
    vq.push_back(mk(0,0,0,1,0, 5, 0, 0, 0, 0, 0));  // CHECK
    vq.push_back(mk(0,0,0,1,0, 1, 0, 1, 0, 0, 0));  // READY + Respawn
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0,0,0,1,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 2, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0,1,0, 3, 0, 0, 0, 0, 0));  // second death
    vq.push_back(mk(0,1,0,0,0, 3, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 4, 1, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0,0,0, 5, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0,0,0, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 2, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0,1,0, 3, 0, 0, 0, 0, 0));  // third death
    vq.push_back(mk(0,1,0,0,0, 3, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 4, 1, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0,0,0, 5, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0,0,0, 7, 0, 0, 0, 0, 0));  // OVER
    vq.push_back(mk(0,1,0,0,0, 7, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 0, 0, 0, 0, 0, 0));  // back to IDLE
    vq.push_back(mk(0,0,1,0,0, 1, 0, 1, 1, 0, 0));  // new game
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 2, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,0,0,1,1, 6, 0, 0, 0, 0, 0));  // Dots_done beats Caught
    vq.push_back(mk(0,1,0,0,0, 6, 0, 0, 0, 0, 0));
    vq.push_back(mk(0,1,0,0,0, 1, 0, 1, 0, 1, 1));  // Level_up, level 1
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0,1,0,0,0, 1, 0, 0, 0, 0, 1));
    vq.push_back(mk(0,1,0,0,0, 2, 0, 0, 0, 0, 1));
    vq.push_back(mk(0,0,0,1,0, 3, 0, 0, 0, 0, 1));
    vq.push_back(mk(0,1,0,0,0, 3, 0, 0, 0, 0, 1));  // 1 tick remaining
    vq.push_back(mk(1,1,0,0,0, 0, 0, 0, 0, 0, 0));  // Reset wins over tick
    vq.push_back(mk(0,0,0,0,0, 0, 0, 0, 0, 0, 0));  // no Restart afterwards

    @(negedge clk);
    foreach (vq[i]) begin
      vec_t v;
      logic [6:0] ef;
      v = vq[i];
      step(v.r, v.t, v.s, v.c, v.d);
      ef = {v.st != 3'd2, v.rs, v.rp, v.ng, v.lu, v.st == 3'd1, v.st == 3'd7};
      check($sformatf("vec%0d.state", i), 32'(state), 32'(v.st));
      check($sformatf("vec%0d.level", i), 32'(level), 32'(v.lv));
      check($sformatf("vec%0d.flags", i), 32'(dut_flags()), 32'(ef));
    end

    // Level saturation: 16 consecutive clears.
    step(1,0,0,0,0);
    step(0,0,1,0,0);
    for (int k = 1; k <= 16; k++) begin
      for (int j = 0; j < RF; j++) step(0,1,0,0,0);
      step(0,0,0,0,1);
      for (int j = 0; j < CF; j++) step(0,1,0,0,0);
      check($sformatf("sat%0d.level", k), 32'(level), (k > 15) ? 32'd15 : 32'(k));
      check($sformatf("sat%0d.level_up", k), 32'(level_up), 32'd1);
    end

    // Randomized run against the phase model.
    step(1,0,0,0,0);
    for (int n = 0; n < 4000; n++) begin
      logic [6:0] ef;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 31) == 0);
      ef = {m_ph != P_PLAY, m_ph == P_LOSE, m_rp, m_ng, m_lu,
            m_ph == P_READY, m_ph == P_OVER};
      check($sformatf("rnd%0d.state", n), 32'(state), 32'(m_ph));
      check($sformatf("rnd%0d.level", n), 32'(level), 32'(m_lvl));
      check($sformatf("rnd%0d.flags", n), 32'(dut_flags()), 32'(ef));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
